// File: rtl/copper_arb_pkg.sv
// copper_arb_pkg: shared types for the copper/CPU bus arbiter.
//   arb_state_e : arbiter FSM state (2-bit)
//   GNT_*       : one-hot grant encodings seen on gnt_o
//   bus_req_t   : master-side request bundle routed to the slave port
package copper_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_M0    = 2'd1,
    ARB_M1    = 2'd2,
    ARB_ABORT = 2'd3
  } arb_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } bus_req_t;

endpackage

// File: rtl/copper_bus_arb.sv
// copper_bus_arb: two-master arbiter for the system-bus master port.
//   Master 0 = copper list engine (fixed priority), master 1 = CPU video path.
//   A starvation counter forces a CPU grant after STARVE_LIM lost cycles, and
//   a bus timeout turns a missing ack into an error so neither master hangs.
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   m{0,1}_cyc/stb/we/sel/adr/dat_i  master requests
//   m{0,1}_ack/err/dat_o           master completions (only granted master sees them)
//   cyc/stb/we/sel/adr/dat_o       slave-side bus (all 0 when idle or aborting)
//   ack_i, err_i, dat_i            slave completion
//   gnt_o                          one-hot grant, 00 when no master owns the bus
//   tmo_o                          one-cycle pulse per timeout abort
module copper_bus_arb
  import copper_arb_pkg::*;
#(
  parameter int STARVE_LIM = 15,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic [31:0] dat_i,
  output logic [1:0]  gnt_o,
  output logic        tmo_o
);

  localparam logic [3:0] SLIM = 4'(STARVE_LIM);
  localparam logic [7:0] TLIM = 8'(TIMEOUT);

  arb_state_e state_q, state_d;
  logic       own_q, own_d;     // owner of the current/aborted cycle: 1 = M1
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  bus_req_t m0_req, m1_req, bus;
  logic     granted, cur_cyc, starved, tmo_hit;

  assign m0_req = {m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i};
  assign m1_req = {m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i};

  assign granted = (state_q == ARB_M0) || (state_q == ARB_M1);
  assign cur_cyc = own_q ? m1_cyc_i : m0_cyc_i;
  assign starved = (starve_cnt_q == SLIM) && m1_cyc_i;
  // An ack/err landing on the terminal count wins over the timeout.
  assign tmo_hit = granted && (tmo_cnt_q == TLIM) && !ack_i && !err_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      own_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (m0_cyc_i && !starved) begin
          state_d = ARB_M0;
          own_d   = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = ARB_M1;
          own_d   = 1'b1;
        end
      end
      ARB_M0, ARB_M1: begin
        // Owner dropping cyc always ends the tenure; a forced IDLE cycle
        // separates consecutive grants.
        if (!cur_cyc)     state_d = ARB_IDLE;
        else if (tmo_hit) state_d = ARB_ABORT;
      end
      ARB_ABORT: begin
        if (!cur_cyc) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Output logic: slave mux and return path are combinational from state_q
  always_comb begin
    bus      = '0;
    gnt_o    = GNT_NONE;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_dat_o = '0;
    unique case (state_q)
      ARB_M0: begin
        bus      = m0_req;
        gnt_o    = GNT_M0;
        m0_ack_o = ack_i;
        m0_err_o = err_i | tmo_hit;
        m0_dat_o = dat_i;
      end
      ARB_M1: begin
        bus      = m1_req;
        gnt_o    = GNT_M1;
        m1_ack_o = ack_i;
        m1_err_o = err_i | tmo_hit;
        m1_dat_o = dat_i;
      end
      default: ;
    endcase
  end

  assign cyc_o = bus.cyc;
  assign stb_o = bus.stb;
  assign we_o  = bus.we;
  assign sel_o = bus.sel;
  assign adr_o = bus.adr;
  assign dat_o = bus.dat;
  assign tmo_o = tmo_hit;

  // Counters
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (!granted)               tmo_cnt_d = '0;  // held clear so entry starts at 0
    else if (ack_i || err_i)    tmo_cnt_d = '0;
    else if (stb_o && tmo_cnt_q != TLIM) tmo_cnt_d = tmo_cnt_q + 8'd1;

    starve_cnt_d = starve_cnt_q;
    if (state_q == ARB_IDLE && state_d == ARB_M1)
      starve_cnt_d = '0;
    else if (m1_cyc_i && gnt_o != GNT_M1 && starve_cnt_q != SLIM)
      starve_cnt_d = starve_cnt_q + 4'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q    <= '0;
      starve_cnt_q <= '0;
    end else begin
      tmo_cnt_q    <= tmo_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_copper_bus_arb.sv
module tb_copper_bus_arb;
  localparam int SL  = 15;
  localparam int TMO = 255;

  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
  logic [3:0]  m0_sel_i = 0;
  logic [31:0] m0_adr_i = 0, m0_dat_i = 0;
  logic        m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
  logic [3:0]  m1_sel_i = 0;
  logic [31:0] m1_adr_i = 0, m1_dat_i = 0;
  logic        ack_i = 0, err_i = 0;
  logic [31:0] dat_i = 0;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        cyc_o, stb_o, we_o, tmo_o;
  logic [3:0]  sel_o;
  logic [31:0] adr_o, dat_o;
  logic [1:0]  gnt_o;

  copper_bus_arb #(.STARVE_LIM(SL), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o), .adr_o(adr_o), .dat_o(dat_o),
    .ack_i(ack_i), .err_i(err_i), .dat_i(dat_i),
    .gnt_o(gnt_o), .tmo_o(tmo_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: who owns the bus (0 none, 1 copper, 2 CPU), whether
  // that ownership has been aborted, how long the strobe has gone unanswered
  // and how long the CPU has been kept waiting.
  int own = 0, tcnt = 0, scnt = 0;
  bit abt = 0;

  always @(negedge clk_i) begin : model
    logic [141:0] ev, av;
    logic c, s, w, fire, m1_in;
    logic [3:0]  sl;
    logic [31:0] ad, dt;
    logic [1:0]  eg;
    int nown;
    ev    = '0;
    fire  = 1'b0;
    m1_in = 1'b0;
    c  = (own == 2) ? m1_cyc_i : m0_cyc_i;
    s  = (own == 2) ? m1_stb_i : m0_stb_i;
    w  = (own == 2) ? m1_we_i  : m0_we_i;
    sl = (own == 2) ? m1_sel_i : m0_sel_i;
    ad = (own == 2) ? m1_adr_i : m0_adr_i;
    dt = (own == 2) ? m1_dat_i : m0_dat_i;
    if (rst_ni && own != 0 && !abt) begin
      fire = (tcnt == TMO) && !ack_i && !err_i;
      eg = (own == 1) ? 2'b01 : 2'b10;
      ev = {c, s, w, sl, ad, dt, eg, fire,
            (own == 1) && ack_i, (own == 1) && (err_i || fire), (own == 1) ? dat_i : 32'h0,
            (own == 2) && ack_i, (own == 2) && (err_i || fire), (own == 2) ? dat_i : 32'h0};
    end
    av = {cyc_o, stb_o, we_o, sel_o, adr_o, dat_o, gnt_o, tmo_o,
          m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o, m1_err_o, m1_dat_o};
    n_chk++;
    if (av !== ev) begin
      n_fail++;
      $display("FAIL model_cycle t=%0t: outputs %h expected %h", $time, av, ev);
    end

    if (!rst_ni) begin
      own = 0; abt = 0; tcnt = 0; scnt = 0;
    end else begin
      nown = own;
      if (own == 0) begin
        if (m0_cyc_i && !(scnt == SL && m1_cyc_i)) begin nown = 1; tcnt = 0; end
        else if (m1_cyc_i) begin nown = 2; tcnt = 0; m1_in = 1; end
      end else if (!c) begin
        nown = 0; abt = 0;
      end else if (!abt) begin
        if (fire) abt = 1;
        else if (ack_i || err_i) tcnt = 0;
        else if (s) tcnt = tcnt + 1;
      end
      if (m1_in) scnt = 0;
      else if (m1_cyc_i && !(own == 2 && !abt) && scnt < SL) scnt = scnt + 1;
      own = nown;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drop_all();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 0; m0_adr_i = 0; m0_dat_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 0; m1_adr_i = 0; m1_dat_i = 0;
    ack_i = 0; err_i = 0; dat_i = 0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, n_m0;
    bit done;
    #2;
    chk("rst_cyc", cyc_o, 0);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_acks", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 0);
    repeat (3) step();
    rst_ni = 1;
    step();

    // Copper-only write
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 4'hF;
    m0_adr_i = 32'hFD080010; m0_dat_i = 32'h12345678;
    #1 chk("t1_idle_cyc", cyc_o, 0);
    step();
    chk("t1_cyc", cyc_o, 1);
    chk("t1_adr", adr_o, 32'hFD080010);
    chk("t1_dat", dat_o, 32'h12345678);
    chk("t1_gnt", gnt_o, 2'b01);
    step();
    ack_i = 1;
    #1 chk("t1_ack", m0_ack_o, 1);
    chk("t1_m1_ack", m1_ack_o, 0);
    step();
    drop_all();
    step();
    chk("t1_gnt_idle", gnt_o, 2'b00);

    // Both request at once: copper first, one IDLE cycle, then CPU read
    m0_cyc_i = 1; m0_stb_i = 1; m0_sel_i = 4'hF; m0_adr_i = 32'hFD080020;
    m1_cyc_i = 1; m1_stb_i = 1; m1_sel_i = 4'hF; m1_adr_i = 32'hFD0000A0;
    step();
    chk("t2_gnt_m0", gnt_o, 2'b01);
    ack_i = 1;
    step();
    ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    step();
    chk("t2_gnt_idle", gnt_o, 2'b00);
    step();
    chk("t2_gnt_m1", gnt_o, 2'b10);
    chk("t2_adr_m1", adr_o, 32'hFD0000A0);
    dat_i = 32'hCAFEF00D; ack_i = 1;
    #1 chk("t2_m1_dat", m1_dat_o, 32'hCAFEF00D);
    chk("t2_m1_ack", m1_ack_o, 1);
    chk("t2_m0_dat", m0_dat_o, 0);
    step();
    drop_all();
    step();

    // Starvation: copper streams single-cycle transactions, CPU waits
    m1_cyc_i = 1; m1_stb_i = 1; m1_sel_i = 4'hF; m1_adr_i = 32'hFD0000B0;
    n_m0 = 0; done = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      m0_cyc_i = 1; m0_stb_i = 1; m0_sel_i = 4'h3; m0_adr_i = 32'hFD080100 + k;
      step();
      if (gnt_o == 2'b10) done = 1;
      else begin
        n_m0++;
        ack_i = 1;
        step();
        ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        step();
      end
    end
    chk("t3_m0_wins", n_m0, 5);
    chk("t3_gnt_m1", gnt_o, 2'b10);
    ack_i = 1;
    step();
    drop_all();
    step();
    step();

    // Timeout on the CPU
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_sel_i = 4'hF; m1_adr_i = 32'hFD0000C0;
    step();
    chk("t4_stb_rise", stb_o, 1);
    n = 0;
    while (!tmo_o && n < 400) begin
      step();
      n++;
    end
    chk("t4_tmo_cycle", n, 255);
    chk("t4_m1_err", m1_err_o, 1);
    step();
    chk("t4_abort_cyc", cyc_o, 0);
    chk("t4_abort_tmo", {tmo_o, m1_err_o}, 0);
    repeat (3) step();
    chk("t4_hold_cyc", cyc_o, 0);
    drop_all();
    step();
    step();

    // Ack on the terminal-count cycle
    m0_cyc_i = 1; m0_stb_i = 1; m0_sel_i = 4'hF; m0_adr_i = 32'hFD080200;
    step();
    repeat (255) step();
    ack_i = 1;
    #1 chk("t5_ack", m0_ack_o, 1);
    chk("t5_err_tmo", {m0_err_o, tmo_o}, 0);
    step();
    drop_all();
    step();

    // Async reset mid-burst, then a fresh CPU request
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_sel_i = 4'hF; m0_adr_i = 32'hFD080300;
    step();
    ack_i = 1;
    step();
    #1 rst_ni = 0;
    #1 chk("t6_rst_bus", {cyc_o, stb_o}, 0);
    chk("t6_rst_gnt", gnt_o, 0);
    chk("t6_rst_acks", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 0);
    step();
    drop_all();
    m1_cyc_i = 1; m1_stb_i = 1; m1_sel_i = 4'hF; m1_adr_i = 32'hFD0000D0;
    step();
    rst_ni = 1;
    step();
    chk("t6_gnt_m1", gnt_o, 2'b10);
    ack_i = 1;
    step();
    drop_all();
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
